bus_uart_tx_responder: RTL and testbench
========================================

Name: bus_uart_tx_responder

Overview:
Memory-mapped UART transmitter that acts as the responder on the CPU data bus (strb/busWe/busAddr/busWData/busRData).
- CPU stores bytes into a TX FIFO and polls status; the block serialises the bytes 8N1 on a pin.
- Sits behind the bus address decoder, which supplies a chip select.
- Reads are combinational, because the single-cycle CPU samples busRData in the same cycle. Writes commit on the clock edge.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.
- BAUD_RST, 16'd867, reset value of BAUDDIV; bit period is BAUDDIV+1 clocks (115200 baud at 100 MHz).

Ports:
- clk       input   1   system clock
- reset     input   1   synchronous, active-high
- busSel    input   1   chip select from address decoder
- busWe     input   1   1 = store, 0 = load
- busAddr   input   32  byte address; only [3:2] decoded
- strb      input   3   access size: [1:0] 00 byte / 01 half / 10 word; [2] unsigned-load flag, ignored here
- busWData  input   32  store data, lane-aligned at bit 0
- busRData  output  32  load data, combinational
- tx        output  1   serial line, idles high
- txIrq     output  1   level interrupt: FIFO empty and TX idle

Behaviour:
Register map (offset = busAddr[3:2]):
- 0 TXDATA, W: push busWData[7:0]; R: 0.
- 1 STATUS, R:
  - bit0 busy (FSM not IDLE)
  - bit1 full
  - bit2 empty
  - bit3 overflow (sticky)
  - [15:8] FIFO count
  - STATUS write with busWData[3]=1 clears overflow.
- 2 BAUDDIV, RW [15:0].
  - Byte store updates [7:0] only; half or word store updates [15:0].
- 3 CTRL, RW.
  - bit0 enable, reset 0.
  - Other bits read 0.

Bus access rules:
- Write strobe = busSel & busWe, sampled at posedge clk.
- busRData = selected register when busSel & ~busWe, else 32'h0.

Reset values:
- tx=1, txIrq=1, FIFO empty, overflow=0, BAUDDIV=BAUD_RST, CTRL=0, FSM IDLE.
- A reset asserted mid-frame forces tx=1 at the next edge and flushes the FIFO.

FIFO:
- Push to a full FIFO: byte dropped, overflow set.
- Push and pop in the same cycle: both happen, count unchanged.
- Push to an empty FIFO while the FSM pops is impossible; pop occurs only when not empty.

FSM (IDLE, START, DATA, STOP):
- IDLE: when enable=1 and FIFO not empty:
  - pop the head into the shift register,
  - latch BAUDDIV into the bit counter limit,
  - go to START; tx=0 from the next cycle.
- Each state lasts one bit period, measured by a 16-bit counter that counts 0..limit and then ticks.
- DATA: shifts out 8 bits LSB first, with a 3-bit bit index.
- STOP: tx=1 for one period, then IDLE.
- Back-to-back frames: IDLE lasts exactly 1 cycle between STOP and the next START.
- enable cleared mid-frame: current frame completes; no new frame starts.
- BAUDDIV written mid-frame: takes effect from the next frame.
- Frame length = 10*(BAUDDIV+1) clocks, plus 1 idle cycle.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - CTRL bit1 = parity enable (RW, reset 0).
  - When CTRL bit1 = 1, a PARITY state between DATA and STOP sends even parity (XOR of the 8 data bits).
  - Frame is 11 bit periods.
- Undefined:
  - CTRL bit1 reads 0 and writes are ignored.
  - No PARITY state; always 8N1.

Decomposition:
- Package uart_tx_pkg:
  - register offset constants,
  - strb size encodings (SIZE_B/SIZE_H/SIZE_W),
  - STATUS bit indices,
  - FSM state enum.
- Sub-module tx_fifo, a synchronous FIFO:
  - parameters WIDTH=8, DEPTH,
  - ports push, pop, din, dout (head, combinational), full, empty, count.

Test Plan:
- Reset, then read STATUS, BAUDDIV and CTRL → STATUS=32'h0000_0004, BAUDDIV=867, CTRL=0, tx=1, txIrq=1.
- Set BAUDDIV=3, enable=1, store 8'hA5 → tx low 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high 4 clocks; busy=1 throughout; txIrq returns to 1 after STOP.
- Enable=0, push 8 bytes (FIFO_DEPTH=8), then a 9th → full=1, count=8, overflow=1. Write STATUS with bit3 set → overflow=0.
- BAUDDIV=1, enable, push 3 bytes → three contiguous frames, each 20 clocks, separated by exactly 1 idle cycle; count decrements on each START.
- Mid-DATA, clear enable and write BAUDDIV=5 → current frame finishes at the old rate; no further frames; re-enable → next frame uses 6-clock bits.
- Assert reset during DATA → next cycle tx=1, count=0, busy=0. With UART_TX_PARITY_EN and CTRL=3, sending 8'h07 gives parity bit 1.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the bus-mapped UART transmitter.
//   - register offsets (busAddr[3:2])
//   - store size encodings carried on strb[1:0]
//   - STATUS / CTRL bit positions
//   - transmit FSM state type
package uart_tx_pkg;

    // Register offsets, decoded from busAddr[3:2]
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // Access size on strb[1:0]
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // STATUS bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    // CTRL bit positions
    localparam int CTRL_EN  = 0;
    localparam int CTRL_PAR = 1;

    // PARITY is only reachable when the parity option is compiled in
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Even parity bit: makes the total count of ones (data + parity) even
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/bus_uart_tx_responder_fifo.sv
// tx_fifo: synchronous FIFO holding bytes waiting for transmission.
//   clk, srst   : clock, synchronous active-high reset (flushes contents)
//   push, din   : write request and data; ignored when full
//   pop         : read request; ignored when empty
//   dout        : current head entry (combinational)
//   full, empty : occupancy flags
//   count       : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Storage has no reset so it can map onto plain memory
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            // Simultaneous push and pop leaves the count unchanged
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/bus_uart_tx_responder.sv
// bus_uart_tx_responder: memory-mapped UART transmitter (bus responder).
//   The CPU pushes bytes into a TX FIFO through TXDATA and polls STATUS;
//   the bytes are serialised 8N1 (LSB first) on tx.
//   Optional build macro UART_TX_PARITY_EN adds CTRL bit1 (even parity
//   enable) and a PARITY bit period between DATA and STOP.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   busSel            : chip select from the address decoder
//   busWe             : 1 = store, 0 = load
//   busAddr[31:0]     : byte address, only [3:2] decoded
//   strb[2:0]         : [1:0] access size (byte/half/word), [2] unused
//   busWData[31:0]    : store data, lane-aligned at bit 0
//   busRData[31:0]    : load data, combinational, 0 when not reading
//   tx                : serial output, idles high
//   txIrq             : level interrupt, FIFO empty and transmitter idle
// Registers: 0 TXDATA (W), 1 STATUS (R, W1C overflow on bit3),
//            2 BAUDDIV (RW [15:0]), 3 CTRL (RW bit0 enable).
module bus_uart_tx_responder
    import uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] BAUD_RST   = 16'd867
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        busSel,
    input  logic        busWe,
    input  logic [31:0] busAddr,
    input  logic [2:0]  strb,
    input  logic [31:0] busWData,
    output logic [31:0] busRData,
    output logic        tx,
    output logic        txIrq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ---------------- bus decode ----------------
    logic       wr_en;
    logic       rd_en;
    logic [1:0] reg_off;

    assign wr_en   = busSel & busWe;
    assign rd_en   = busSel & ~busWe;
    assign reg_off = busAddr[3:2];

    // Address bits outside [3:2], the unsigned-load flag and the upper
    // data lanes carry nothing for this block.
    logic unused_bits;
    assign unused_bits = &{1'b0, busAddr[31:4], busAddr[1:0], strb[2],
                           busWData[31:16]};

    // ---------------- FIFO ----------------
    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    assign fifo_push = wr_en && (reg_off == REG_TXDATA);

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (busWData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---------------- control registers ----------------
    logic [15:0] baud_div_reg;
    logic        enable_reg;
    logic        ovf_reg;
    logic        par_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_div_reg <= BAUD_RST;
            enable_reg   <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            // A push and a clear cannot coincide: they target different offsets
            if (fifo_push && fifo_full) begin
                ovf_reg <= 1'b1;
            end else if (wr_en && (reg_off == REG_STATUS) && busWData[STAT_OVF]) begin
                ovf_reg <= 1'b0;
            end

            if (wr_en && (reg_off == REG_BAUDDIV)) begin
                unique case (strb[1:0])
                    SIZE_B:  baud_div_reg[7:0] <= busWData[7:0];
                    SIZE_H:  baud_div_reg      <= busWData[15:0];
                    SIZE_W:  baud_div_reg      <= busWData[15:0];
                    default: baud_div_reg      <= busWData[15:0];
                endcase
            end

            if (wr_en && (reg_off == REG_CTRL)) begin
                enable_reg <= busWData[CTRL_EN];
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    logic par_en_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_en_reg <= 1'b0;
        end else if (wr_en && (reg_off == REG_CTRL)) begin
            par_en_reg <= busWData[CTRL_PAR];
        end
    end

    assign par_en = par_en_reg;
`else
    assign par_en = 1'b0;
`endif

    // ---------------- transmit FSM ----------------
    tx_state_t   state_reg,     state_next;
    logic [15:0] cnt_reg,       cnt_next;
    logic [15:0] limit_reg,     limit_next;
    logic [7:0]  shift_reg,     shift_next;
    logic [2:0]  idx_reg,       idx_next;
    logic        par_bit_reg,   par_bit_next;
    logic        par_frame_reg, par_frame_next;
    logic        tx_reg,        tx_next;
    logic        tick;
    logic        busy;

    // Bit period ends when the counter has walked 0..limit
    assign tick = (cnt_reg == limit_reg);
    assign busy = (state_reg != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            limit_reg     <= '0;
            shift_reg     <= '0;
            idx_reg       <= '0;
            par_bit_reg   <= 1'b0;
            par_frame_reg <= 1'b0;
            tx_reg        <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            limit_reg     <= limit_next;
            shift_reg     <= shift_next;
            idx_reg       <= idx_next;
            par_bit_reg   <= par_bit_next;
            par_frame_reg <= par_frame_next;
            tx_reg        <= tx_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        limit_next     = limit_reg;
        shift_next     = shift_reg;
        idx_next       = idx_reg;
        par_bit_next   = par_bit_reg;
        par_frame_next = par_frame_reg;
        tx_next        = tx_reg;
        fifo_pop       = 1'b0;

        if (state_reg != ST_IDLE) begin
            cnt_next = tick ? 16'd0 : cnt_reg + 16'd1;
        end

        unique case (state_reg)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (enable_reg && !fifo_empty) begin
                    // Divider and parity mode are frozen for the whole frame,
                    // so register writes mid-frame only affect the next one.
                    fifo_pop       = 1'b1;
                    shift_next     = fifo_dout;
                    limit_next     = baud_div_reg;
                    cnt_next       = 16'd0;
                    idx_next       = 3'd0;
                    par_bit_next   = even_parity(fifo_dout);
                    par_frame_next = par_en;
                    state_next     = ST_START;
                    tx_next        = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_next = ST_DATA;
                    tx_next    = shift_reg[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx_reg == 3'd7) begin
                        if (par_frame_reg) begin
                            state_next = ST_PARITY;
                            tx_next    = par_bit_reg;
                        end else begin
                            state_next = ST_STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        // shift_reg[0] is always the bit currently on the line
                        idx_next   = idx_reg + 3'd1;
                        shift_next = {1'b0, shift_reg[7:1]};
                        tx_next    = shift_reg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_next = ST_STOP;
                    tx_next    = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_next = ST_IDLE;
                    tx_next    = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    // ---------------- outputs ----------------
    assign tx    = tx_reg;
    assign txIrq = fifo_empty & ~busy;

    logic [31:0] status_word;

    always_comb begin
        status_word                             = '0;
        status_word[STAT_BUSY]                  = busy;
        status_word[STAT_FULL]                  = fifo_full;
        status_word[STAT_EMPTY]                 = fifo_empty;
        status_word[STAT_OVF]                   = ovf_reg;
        status_word[STAT_CNT_LSB +: 8]          = 8'(fifo_count);
    end

    always_comb begin
        busRData = 32'h0;
        if (rd_en) begin
            unique case (reg_off)
                REG_TXDATA:  busRData = 32'h0;
                REG_STATUS:  busRData = status_word;
                REG_BAUDDIV: busRData = {16'h0, baud_div_reg};
                REG_CTRL:    busRData = {30'h0, par_en, enable_reg};
                default:     busRData = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_uart_tx_responder.sv
// Testbench for bus_uart_tx_responder. Expected line waveforms are built
// from the frame format (idle, start, 8 data bits LSB first, optional
// even parity, stop), each bit lasting BAUDDIV+1 clocks.
module tb_bus_uart_tx_responder;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;
    localparam logic [1:0] OFF_CTRL    = 2'd3;
    localparam logic [2:0] SZ_B = 3'b000;
    localparam logic [2:0] SZ_H = 3'b001;
    localparam logic [2:0] SZ_W = 3'b010;

    logic        clk = 1'b0;
    logic        reset;
    logic        busSel;
    logic        busWe;
    logic [31:0] busAddr;
    logic [2:0]  strb;
    logic [31:0] busWData;
    logic [31:0] busRData;
    logic        tx;
    logic        txIrq;

    int vectors = 0;
    int errors  = 0;

    logic        exp_tx[$];
    logic        exp_busy[$];
    logic        exp_irq[$];
    int          exp_cnt[$];
    logic        cap_tx[$];
    logic        cap_irq[$];
    logic [31:0] cap_st[$];

    bus_uart_tx_responder #(
        .FIFO_DEPTH (8),
        .BAUD_RST   (16'd867)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .busSel   (busSel),
        .busWe    (busWe),
        .busAddr  (busAddr),
        .strb     (strb),
        .busWData (busWData),
        .busRData (busRData),
        .tx       (tx),
        .txIrq    (txIrq)
    );

    always #5 clk = ~clk;

    // ---------------- bus helpers (all start at posedge+1) ----------------
    task automatic bus_write(input logic [1:0] off, input logic [31:0] d, input logic [2:0] sz);
        busSel   = 1'b1;
        busWe    = 1'b1;
        busAddr  = {28'h0, off, 2'b00};
        busWData = d;
        strb     = sz;
        @(posedge clk);
        #1;
        busSel   = 1'b0;
        busWe    = 1'b0;
        busWData = 32'h0;
        busAddr  = 32'h0;
    endtask

    task automatic bus_read(input logic [1:0] off, output logic [31:0] d);
        busSel  = 1'b1;
        busWe   = 1'b0;
        busAddr = {28'h0, off, 2'b00};
        #1;
        d = busRData;
        busSel  = 1'b0;
        busAddr = 32'h0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: expected per-cycle line state after the cycle that
    // makes the FSM see a non-empty FIFO with enable set.
    task automatic build_wave(input logic [7:0] bytes[$], input int L, input bit par,
                              input int extra, input int tail);
        int   rem;
        logic bq[$];
        exp_tx.delete(); exp_busy.delete(); exp_irq.delete(); exp_cnt.delete();
        rem = bytes.size() + extra;
        foreach (bytes[k]) begin
            exp_tx.push_back(1'b1); exp_busy.push_back(1'b0);
            exp_irq.push_back(1'b0); exp_cnt.push_back(rem);
            rem--;
            bq.delete();
            bq.push_back(1'b0);
            for (int j = 0; j < 8; j++) bq.push_back(bytes[k][j]);
            if (par) bq.push_back(^bytes[k]);
            bq.push_back(1'b1);
            foreach (bq[b]) begin
                repeat (L + 1) begin
                    exp_tx.push_back(bq[b]); exp_busy.push_back(1'b1);
                    exp_irq.push_back(1'b0); exp_cnt.push_back(rem);
                end
            end
        end
        repeat (tail) begin
            exp_tx.push_back(1'b1); exp_busy.push_back(1'b0);
            exp_irq.push_back(rem == 0); exp_cnt.push_back(rem);
        end
    endtask

    task automatic capture(input int n, input bit use_bus);
        cap_tx.delete(); cap_irq.delete(); cap_st.delete();
        if (use_bus) begin
            busSel  = 1'b1;
            busWe   = 1'b0;
            busAddr = {28'h0, OFF_STATUS, 2'b00};
        end
        #1;
        for (int i = 0; i < n; i++) begin
            cap_tx.push_back(tx);
            cap_irq.push_back(txIrq);
            cap_st.push_back(busRData);
            @(posedge clk);
            #1;
        end
        if (use_bus) begin
            busSel  = 1'b0;
            busAddr = 32'h0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] r;
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        vectors++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        vectors++;
        if (txIrq !== 1'b1) begin errors++; $display("FAIL reset_irq: got %b expected 1", txIrq); end
        bus_read(OFF_STATUS, r);
        vectors++;
        if (r !== 32'h0000_0004) begin errors++; $display("FAIL reset_status: got %h expected 00000004", r); end
        bus_read(OFF_BAUDDIV, r);
        vectors++;
        if (r !== 32'd867) begin errors++; $display("FAIL reset_baud: got %0d expected 867", r); end
        bus_read(OFF_CTRL, r);
        vectors++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", r); end
        vectors++;
        if (busRData !== 32'h0) begin errors++; $display("FAIL idle_rdata: got %h expected 0", busRData); end
        $display("test_reset: status/baud/ctrl/tx/irq checked");
    endtask

    task automatic test_regs();
        logic [31:0] r;
        logic [31:0] exp_ctrl;
        @(posedge clk); #1;
        bus_write(OFF_BAUDDIV, 32'h1234_5678, SZ_W);
        bus_read(OFF_BAUDDIV, r);
        vectors++;
        if (r !== 32'h0000_5678) begin errors++; $display("FAIL baud_word: got %h expected 00005678", r); end
        bus_write(OFF_BAUDDIV, 32'hFFFF_FFAB, SZ_B);
        bus_read(OFF_BAUDDIV, r);
        vectors++;
        if (r !== 32'h0000_56AB) begin errors++; $display("FAIL baud_byte: got %h expected 000056AB", r); end
        bus_write(OFF_BAUDDIV, 32'hFFFF_9ABC, SZ_H);
        bus_read(OFF_BAUDDIV, r);
        vectors++;
        if (r !== 32'h0000_9ABC) begin errors++; $display("FAIL baud_half: got %h expected 00009ABC", r); end
        bus_write(OFF_CTRL, 32'hFFFF_FFFF, SZ_W);
        bus_read(OFF_CTRL, r);
`ifdef UART_TX_PARITY_EN
        exp_ctrl = 32'h3;
`else
        exp_ctrl = 32'h1;
`endif
        vectors++;
        if (r !== exp_ctrl) begin errors++; $display("FAIL ctrl_rw: got %h expected %h", r, exp_ctrl); end
        bus_read(OFF_TXDATA, r);
        vectors++;
        if (r !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h expected 0", r); end
        bus_write(OFF_CTRL, 32'h0, SZ_W);
        @(posedge clk); #1;
        $display("test_regs: bauddiv sizes, ctrl, txdata read checked");
    endtask

    task automatic test_frame();
        logic [7:0] q[$];
        int bad_tx, bad_busy, bad_cnt, bad_irq;
        bus_write(OFF_BAUDDIV, 32'd3, SZ_W);
        bus_write(OFF_CTRL, 32'd1, SZ_W);
        for (int f = 0; f < 3; f++) begin
            q.delete();
            q.push_back((f == 0) ? 8'hA5 : 8'($urandom_range(0, 255)));
            build_wave(q, 3, 1'b0, 0, 1);
            bus_write(OFF_TXDATA, {24'h0, q[0]}, SZ_B);
            capture(exp_tx.size(), 1'b1);
            bad_tx = -1; bad_busy = -1; bad_cnt = -1; bad_irq = -1;
            for (int i = exp_tx.size() - 1; i >= 0; i--) begin
                if (cap_tx[i] !== exp_tx[i]) bad_tx = i;
                if (cap_st[i][0] !== exp_busy[i]) bad_busy = i;
                if (int'(cap_st[i][15:8]) != exp_cnt[i]) bad_cnt = i;
                if (cap_irq[i] !== exp_irq[i]) bad_irq = i;
            end
            vectors++;
            if (bad_tx >= 0) begin errors++; $display("FAIL frame_tx byte %h cycle %0d: got %b expected %b", q[0], bad_tx, cap_tx[bad_tx], exp_tx[bad_tx]); end
            vectors++;
            if (bad_busy >= 0) begin errors++; $display("FAIL frame_busy byte %h cycle %0d: got %b expected %b", q[0], bad_busy, cap_st[bad_busy][0], exp_busy[bad_busy]); end
            vectors++;
            if (bad_cnt >= 0) begin errors++; $display("FAIL frame_count byte %h cycle %0d: got %0d expected %0d", q[0], bad_cnt, cap_st[bad_cnt][15:8], exp_cnt[bad_cnt]); end
            vectors++;
            if (bad_irq >= 0) begin errors++; $display("FAIL frame_irq byte %h cycle %0d: got %b expected %b", q[0], bad_irq, cap_irq[bad_irq], exp_irq[bad_irq]); end
            $display("test_frame: byte %h sent with BAUDDIV=3", q[0]);
        end
    endtask

    task automatic test_overflow();
        logic [7:0]  q[$];
        logic [31:0] r;
        int bad_tx, bad_cnt;
        bus_write(OFF_CTRL, 32'd0, SZ_W);
        for (int i = 0; i < 8; i++) begin
            q.push_back(8'($urandom_range(0, 255)));
            bus_write(OFF_TXDATA, {24'h0, q[i]}, SZ_B);
        end
        bus_read(OFF_STATUS, r);
        vectors++;
        if (r !== 32'h0000_0802) begin errors++; $display("FAIL full_status: got %h expected 00000802", r); end
        bus_write(OFF_TXDATA, 32'($urandom_range(0, 255)), SZ_B);
        bus_read(OFF_STATUS, r);
        vectors++;
        if (r !== 32'h0000_080A) begin errors++; $display("FAIL overflow_status: got %h expected 0000080A", r); end
        bus_write(OFF_STATUS, 32'h0000_0008, SZ_W);
        bus_read(OFF_STATUS, r);
        vectors++;
        if (r !== 32'h0000_0802) begin errors++; $display("FAIL ovf_clear: got %h expected 00000802", r); end
        // Drain: only the first eight bytes may appear on the line
        bus_write(OFF_BAUDDIV, 32'd0, SZ_W);
        build_wave(q, 0, 1'b0, 0, 1);
        bus_write(OFF_CTRL, 32'd1, SZ_W);
        capture(exp_tx.size(), 1'b1);
        bad_tx = -1; bad_cnt = -1;
        for (int i = exp_tx.size() - 1; i >= 0; i--) begin
            if (cap_tx[i] !== exp_tx[i]) bad_tx = i;
            if (int'(cap_st[i][15:8]) != exp_cnt[i]) bad_cnt = i;
        end
        vectors++;
        if (bad_tx >= 0) begin errors++; $display("FAIL drain_tx cycle %0d: got %b expected %b", bad_tx, cap_tx[bad_tx], exp_tx[bad_tx]); end
        vectors++;
        if (bad_cnt >= 0) begin errors++; $display("FAIL drain_count cycle %0d: got %0d expected %0d", bad_cnt, cap_st[bad_cnt][15:8], exp_cnt[bad_cnt]); end
        $display("test_overflow: 9 pushes, overflow set/cleared, 8 bytes drained");
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        int bad_tx, bad_busy, bad_cnt;
        bus_write(OFF_CTRL, 32'd0, SZ_W);
        bus_write(OFF_BAUDDIV, 32'd1, SZ_H);
        for (int i = 0; i < 3; i++) begin
            q.push_back(8'($urandom_range(0, 255)));
            bus_write(OFF_TXDATA, {24'h0, q[i]}, SZ_B);
        end
        build_wave(q, 1, 1'b0, 0, 1);
        bus_write(OFF_CTRL, 32'd1, SZ_W);
        capture(exp_tx.size(), 1'b1);
        bad_tx = -1; bad_busy = -1; bad_cnt = -1;
        for (int i = exp_tx.size() - 1; i >= 0; i--) begin
            if (cap_tx[i] !== exp_tx[i]) bad_tx = i;
            if (cap_st[i][0] !== exp_busy[i]) bad_busy = i;
            if (int'(cap_st[i][15:8]) != exp_cnt[i]) bad_cnt = i;
        end
        vectors++;
        if (bad_tx >= 0) begin errors++; $display("FAIL b2b_tx cycle %0d: got %b expected %b", bad_tx, cap_tx[bad_tx], exp_tx[bad_tx]); end
        vectors++;
        if (bad_busy >= 0) begin errors++; $display("FAIL b2b_busy cycle %0d: got %b expected %b", bad_busy, cap_st[bad_busy][0], exp_busy[bad_busy]); end
        vectors++;
        if (bad_cnt >= 0) begin errors++; $display("FAIL b2b_count cycle %0d: got %0d expected %0d", bad_cnt, cap_st[bad_cnt][15:8], exp_cnt[bad_cnt]); end
        $display("test_back_to_back: %h %h %h with BAUDDIV=1", q[0], q[1], q[2]);
    endtask

    task automatic test_enable_change();
        logic [7:0]  q[$];
        logic [7:0]  b1;
        logic [31:0] r;
        int bad_tx, bad_irq;
        bus_write(OFF_CTRL, 32'd0, SZ_W);
        bus_write(OFF_BAUDDIV, 32'd2, SZ_W);
        q.push_back(8'($urandom_range(0, 255)));
        b1 = 8'($urandom_range(0, 255));
        bus_write(OFF_TXDATA, {24'h0, q[0]}, SZ_B);
        bus_write(OFF_TXDATA, {24'h0, b1}, SZ_B);
        build_wave(q, 2, 1'b0, 1, 10);
        bus_write(OFF_CTRL, 32'd1, SZ_W);
        fork
            capture(exp_tx.size(), 1'b0);
            begin
                wait_cycles(8);
                bus_write(OFF_CTRL, 32'd0, SZ_W);
                bus_write(OFF_BAUDDIV, 32'd5, SZ_W);
            end
        join
        bad_tx = -1; bad_irq = -1;
        for (int i = exp_tx.size() - 1; i >= 0; i--) begin
            if (cap_tx[i] !== exp_tx[i]) bad_tx = i;
            if (cap_irq[i] !== exp_irq[i]) bad_irq = i;
        end
        vectors++;
        if (bad_tx >= 0) begin errors++; $display("FAIL disable_tx cycle %0d: got %b expected %b", bad_tx, cap_tx[bad_tx], exp_tx[bad_tx]); end
        vectors++;
        if (bad_irq >= 0) begin errors++; $display("FAIL disable_irq cycle %0d: got %b expected %b", bad_irq, cap_irq[bad_irq], exp_irq[bad_irq]); end
        bus_read(OFF_STATUS, r);
        vectors++;
        if (r !== 32'h0000_0100) begin errors++; $display("FAIL disable_status: got %h expected 00000100", r); end
        @(posedge clk); #1;
        q.delete();
        q.push_back(b1);
        build_wave(q, 5, 1'b0, 0, 1);
        bus_write(OFF_CTRL, 32'd1, SZ_W);
        capture(exp_tx.size(), 1'b1);
        bad_tx = -1;
        for (int i = exp_tx.size() - 1; i >= 0; i--) begin
            if (cap_tx[i] !== exp_tx[i]) bad_tx = i;
        end
        vectors++;
        if (bad_tx >= 0) begin errors++; $display("FAIL reenable_tx cycle %0d: got %b expected %b", bad_tx, cap_tx[bad_tx], exp_tx[bad_tx]); end
        $display("test_enable_change: frame at old rate, next frame at BAUDDIV=5");
    endtask

    task automatic test_reset_midframe();
        logic [31:0] r;
        bus_write(OFF_CTRL, 32'd0, SZ_W);
        bus_write(OFF_BAUDDIV, 32'd3, SZ_W);
        bus_write(OFF_TXDATA, 32'h0, SZ_B);
        bus_write(OFF_TXDATA, 32'($urandom_range(0, 255)), SZ_B);
        bus_write(OFF_TXDATA, 32'($urandom_range(0, 255)), SZ_B);
        bus_write(OFF_CTRL, 32'd1, SZ_W);
        wait_cycles(12);
        vectors++;
        if (tx !== 1'b0) begin errors++; $display("FAIL midframe_data: got %b expected 0", tx); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++;
        if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b expected 1", tx); end
        bus_read(OFF_STATUS, r);
        vectors++;
        if (r !== 32'h0000_0004) begin errors++; $display("FAIL midreset_status: got %h expected 00000004", r); end
        bus_read(OFF_CTRL, r);
        vectors++;
        if (r !== 32'h0) begin errors++; $display("FAIL midreset_ctrl: got %h expected 0", r); end
        wait_cycles(5);
        vectors++;
        if ({tx, txIrq} !== 2'b11) begin errors++; $display("FAIL post_reset_idle: got %b expected 11", {tx, txIrq}); end
        $display("test_reset_midframe: reset during DATA flushed FIFO and idled line");
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] q[$];
        int bad_tx;
        bus_write(OFF_CTRL, 32'd2, SZ_W);
        bus_write(OFF_BAUDDIV, 32'd1, SZ_W);
        q.push_back(8'h07);
        q.push_back(8'($urandom_range(0, 255)));
        q.push_back(8'($urandom_range(0, 255)));
        foreach (q[i]) bus_write(OFF_TXDATA, {24'h0, q[i]}, SZ_B);
        build_wave(q, 1, 1'b1, 0, 1);
        bus_write(OFF_CTRL, 32'd3, SZ_W);
        capture(exp_tx.size(), 1'b1);
        bad_tx = -1;
        for (int i = exp_tx.size() - 1; i >= 0; i--) begin
            if (cap_tx[i] !== exp_tx[i]) bad_tx = i;
        end
        vectors++;
        if (bad_tx >= 0) begin errors++; $display("FAIL parity_tx cycle %0d: got %b expected %b", bad_tx, cap_tx[bad_tx], exp_tx[bad_tx]); end
        $display("test_parity: %h %h %h with even parity", q[0], q[1], q[2]);
    endtask
`endif

    initial begin
        reset    = 1'b1;
        busSel   = 1'b0;
        busWe    = 1'b0;
        busAddr  = 32'h0;
        strb     = 3'b000;
        busWData = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_regs();
        test_frame();
        test_overflow();
        test_back_to_back();
        test_enable_change();
        test_reset_midframe();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
